// File: rtl/bster_cmd_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bster_cmd_arbiter_if                                          |
// | Brief    : Stream bundle for the bster command arbiter: per-channel      |
// |            command/completion ports, engine-side ports and status.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bster_cmd_arbiter_if #(
   parameter int NB_CHANNELS = 4,
   parameter int AXI4S_WIDTH = 128,
   parameter int OUTSTANDING = 8,
   parameter int CH_W        = $clog2(NB_CHANNELS)
);
   localparam int CNT_W = $clog2(OUTSTANDING + 1);

   // client command side
   logic [NB_CHANNELS-1:0]             s_cmd_tvalid;
   logic [NB_CHANNELS-1:0]             s_cmd_tready;
   logic [NB_CHANNELS*AXI4S_WIDTH-1:0] s_cmd_tdata;
   // client completion side
   logic [NB_CHANNELS-1:0]             s_cpl_tvalid;
   logic [NB_CHANNELS-1:0]             s_cpl_tready;
   logic [NB_CHANNELS*AXI4S_WIDTH-1:0] s_cpl_tdata;
   // engine command side
   logic                               m_cmd_tvalid;
   logic                               m_cmd_tready;
   logic [AXI4S_WIDTH-1:0]             m_cmd_tdata;
   logic [CH_W-1:0]                    m_cmd_tid;
   // engine completion side
   logic                               m_cpl_tvalid;
   logic                               m_cpl_tready;
   logic [AXI4S_WIDTH-1:0]             m_cpl_tdata;
   // status
   logic [CNT_W-1:0]                   outstanding;
   logic                               err_unexpected_cpl;

   // arbiter view
   modport slave (
      input  s_cmd_tvalid, s_cmd_tdata, s_cpl_tready,
      input  m_cmd_tready, m_cpl_tvalid, m_cpl_tdata,
      output s_cmd_tready, s_cpl_tvalid, s_cpl_tdata,
      output m_cmd_tvalid, m_cmd_tdata, m_cmd_tid, m_cpl_tready,
      output outstanding, err_unexpected_cpl
   );

   // environment view (clients plus engine)
   modport master (
      output s_cmd_tvalid, s_cmd_tdata, s_cpl_tready,
      output m_cmd_tready, m_cpl_tvalid, m_cpl_tdata,
      input  s_cmd_tready, s_cpl_tvalid, s_cpl_tdata,
      input  m_cmd_tvalid, m_cmd_tdata, m_cmd_tid, m_cpl_tready,
      input  outstanding, err_unexpected_cpl
   );
endinterface
`default_nettype wire

// File: rtl/bster_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bster_cmd_arbiter                                             |
// | Brief    : Round-robin arbiter of NB_CHANNELS command streams into the   |
// |            engine, with an in-order tag FIFO routing completions back.   |
// |            Interface parameters must match the module parameters.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bster_cmd_arbiter #(
   parameter int NB_CHANNELS = 4,
   parameter int AXI4S_WIDTH = 128,
   parameter int OUTSTANDING = 8,
   parameter int CH_W        = $clog2(NB_CHANNELS)
) (
   input  logic               aclk,
   input  logic               areset,
   bster_cmd_arbiter_if.slave bus
);
   localparam int                AW       = $clog2(OUTSTANDING);
   localparam int                CNT_W    = $clog2(OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(OUTSTANDING);
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NB_CHANNELS - 1);

   // output register towards the engine
   logic                   cmd_valid;
   logic [AXI4S_WIDTH-1:0] cmd_data;
   logic [CH_W-1:0]        cmd_tid;
   // round-robin pointer
   logic [CH_W-1:0]        rr_ptr;
   // tag FIFO
   logic [CH_W-1:0]        tag_mem [OUTSTANDING];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   err_q;

   logic                   hi_found, lo_found;
   logic [CH_W-1:0]        hi_ch, lo_ch, grant_ch;
   logic                   grant;
   logic [AXI4S_WIDTH-1:0] sel_data;
   logic [CH_W-1:0]        head;
   logic                   fifo_empty;
   logic                   head_ready;
   logic                   pop;

   // Round-robin pick: lowest requester at or above the pointer, else lowest overall
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_ch    = '0;
      lo_ch    = '0;
      for (int c = NB_CHANNELS - 1; c >= 0; c--) begin
         if (bus.s_cmd_tvalid[c]) begin
            lo_found = 1'b1;
            lo_ch    = CH_W'(c);
            if (CH_W'(c) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_ch    = CH_W'(c);
            end
         end
      end
      grant_ch = hi_found ? hi_ch : lo_ch;
      // a pop in this cycle does not free a slot, hence the plain count compare
      grant    = !areset && lo_found && (!cmd_valid || bus.m_cmd_tready) && (count < FULL_CNT);
   end

   // Ready to the granted channel only, and select its payload
   always_comb begin
      bus.s_cmd_tready = '0;
      sel_data         = '0;
      for (int c = 0; c < NB_CHANNELS; c++) begin
         if (grant_ch == CH_W'(c)) begin
            bus.s_cmd_tready[c] = grant;
            sel_data            = bus.s_cmd_tdata[c*AXI4S_WIDTH +: AXI4S_WIDTH];
         end
      end
   end

   // Output register: load on grant, drop valid after a handshake with no new grant
   always_ff @(posedge aclk) begin
      if (areset) begin
         cmd_valid <= 1'b0;
         cmd_data  <= '0;
         cmd_tid   <= '0;
      end else if (grant) begin
         cmd_valid <= 1'b1;
         cmd_data  <= sel_data;
         cmd_tid   <= grant_ch;
      end else if (bus.m_cmd_tready) begin
         cmd_valid <= 1'b0;
      end
   end

   // Pointer moves just past the granted channel
   always_ff @(posedge aclk) begin
      if (areset) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
      end
   end

   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr];

   // Completion routing to the head tag; an empty FIFO swallows the beat
   always_comb begin
      bus.s_cpl_tvalid = '0;
      head_ready       = 1'b0;
      for (int c = 0; c < NB_CHANNELS; c++) begin
         if (head == CH_W'(c)) begin
            bus.s_cpl_tvalid[c] = bus.m_cpl_tvalid && !fifo_empty;
            head_ready          = bus.s_cpl_tready[c];
         end
      end
      bus.m_cpl_tready = fifo_empty || head_ready;
      pop              = !fifo_empty && bus.m_cpl_tvalid && head_ready;
   end

   assign bus.s_cpl_tdata = {NB_CHANNELS{bus.m_cpl_tdata}};

   // Tag storage; contents need no reset because the pointers define validity
   always_ff @(posedge aclk) begin
      if (grant) begin
         tag_mem[wr_ptr] <= grant_ch;
      end
   end

   // Tag FIFO pointers and occupancy
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (grant) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         if (grant && !pop)      count <= count + CNT_W'(1);
         else if (!grant && pop) count <= count - CNT_W'(1);
      end
   end

   // One-cycle flag for each completion beat that had no outstanding tag
   always_ff @(posedge aclk) begin
      if (areset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= fifo_empty && bus.m_cpl_tvalid;
      end
   end

   assign bus.m_cmd_tvalid       = cmd_valid;
   assign bus.m_cmd_tdata        = cmd_data;
   assign bus.m_cmd_tid          = cmd_tid;
   assign bus.outstanding        = count;
   assign bus.err_unexpected_cpl = err_q;
endmodule
`default_nettype wire
